// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - program counter, branch-target LUT and run/halt sequencing
module pc_branch_ctrl #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              halt_i,
  input  logic              branch_en_i,
  input  logic              branch_on_zero_i,
  input  logic              zero_flag_i,
  input  logic              overflow_in_i,
  input  logic              ovf_we_i,
  input  logic [LUT_AW-1:0] target_sel_i,
  input  logic              lut_we_i,
  input  logic [LUT_AW-1:0] lut_addr_i,
  input  logic [PC_W-1:0]   lut_data_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              running_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ovf_flag_o
);

  localparam int LUT_N = 1 << LUT_AW;
  localparam logic [PC_W-1:0] PC_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic              running_q;
  logic              done_q;
  logic              err_q;
  logic              ovf_q;
  logic [PC_W-1:0]   lut_q [LUT_N];

  logic              taken;
  logic              lut_wr_ok;
  logic [PC_W-1:0]   lut_rd;

  assign taken     = branch_en_i & (zero_flag_i == branch_on_zero_i);
  assign lut_wr_ok = lut_we_i & ((state_q == S_IDLE) | (state_q == S_HALTED));
  // Read sees the pre-edge contents, so a same-cycle write is not forwarded.
  assign lut_rd    = lut_q[target_sel_i];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < LUT_N; i++) lut_q[i] <= '0;
    end else begin
      if (lut_wr_ok) lut_q[lut_addr_i] <= lut_data_i;

      case (state_q)
        S_IDLE: begin
          pc_q      <= '0;
          running_q <= 1'b0;
          done_q    <= 1'b0;
          if (start_i) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
          end
        end

        S_RUN: begin
          if (ovf_we_i) ovf_q <= overflow_in_i;
          if (halt_i) begin
            state_q   <= S_HALTED;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (taken) begin
            pc_q <= lut_rd;
          end else if (pc_q == PC_MAX) begin
            // Overrun stops the core rather than wrapping to 0.
            state_q   <= S_HALTED;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end

        S_HALTED: begin
          if (start_i) begin
            state_q   <= S_RUN;
            pc_q      <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          pc_q      <= '0;
          running_q <= 1'b0;
          done_q    <= 1'b0;
          err_q     <= 1'b0;
          ovf_q     <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o       = pc_q;
  assign running_o  = running_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign ovf_flag_o = ovf_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb/tb_pc_branch_ctrl.sv - directed self-checking bench for pc_branch_ctrl
module tb_pc_branch_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, halt, branch_en, branch_on_zero, zero_flag;
  logic       overflow_in, ovf_we, lut_we;
  logic [3:0] target_sel, lut_addr;
  logic [9:0] lut_data;
  logic [3:0] lut_data2;

  logic [9:0] pc;
  logic       running, done, err, ovf_flag;
  logic [3:0] pc2;
  logic       running2, done2, err2, ovf_flag2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_branch_ctrl #(.PC_W(10), .LUT_AW(4)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .halt_i(halt),
    .branch_en_i(branch_en), .branch_on_zero_i(branch_on_zero), .zero_flag_i(zero_flag),
    .overflow_in_i(overflow_in), .ovf_we_i(ovf_we), .target_sel_i(target_sel),
    .lut_we_i(lut_we), .lut_addr_i(lut_addr), .lut_data_i(lut_data),
    .pc_o(pc), .running_o(running), .done_o(done), .err_o(err), .ovf_flag_o(ovf_flag)
  );

  pc_branch_ctrl #(.PC_W(4), .LUT_AW(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .halt_i(halt),
    .branch_en_i(branch_en), .branch_on_zero_i(branch_on_zero), .zero_flag_i(zero_flag),
    .overflow_in_i(overflow_in), .ovf_we_i(ovf_we), .target_sel_i(target_sel),
    .lut_we_i(lut_we), .lut_addr_i(lut_addr), .lut_data_i(lut_data2),
    .pc_o(pc2), .running_o(running2), .done_o(done2), .err_o(err2), .ovf_flag_o(ovf_flag2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [3:0] sel, input logic boz, input logic zf);
    branch_en = 1'b1; target_sel = sel; branch_on_zero = boz; zero_flag = zf;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; branch_en = 1'b0; branch_on_zero = 1'b0;
    zero_flag = 1'b0; overflow_in = 1'b0; ovf_we = 1'b0; lut_we = 1'b0;
    target_sel = 4'd0; lut_addr = 4'd0; lut_data = 10'd0; lut_data2 = 4'd0;

    tick(); tick();
    check("rst_pc", pc, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ovf", ovf_flag, 0);
    reset = 1'b0;

    lut_we = 1'b1; lut_addr = 4'd3; lut_data = 10'd40;
    tick();
    lut_we = 1'b0;
    check("idle_pc", pc, 0);
    check("idle_running", running, 0);

    start = 1'b1; tick(); start = 1'b0;
    check("start_running", running, 1);
    check("start_pc", pc, 0);
    check("start_done", done, 0);
    tick(); check("seq_pc1", pc, 1);
    tick(); check("seq_pc2", pc, 2);

    ovf_we = 1'b1; overflow_in = 1'b1;
    tick();
    ovf_we = 1'b0; overflow_in = 1'b0;
    check("seq_pc3", pc, 3);
    check("ovf_latched", ovf_flag, 1);
    tick(); tick();
    check("seq_pc5", pc, 5);
    check("ovf_sticky", ovf_flag, 1);

    branch(4'd3, 1'b1, 1'b1); tick();
    check("br_taken_zero", pc, 40);
    branch(4'd3, 1'b1, 1'b0); tick();
    check("br_not_taken", pc, 41);
    branch(4'd3, 1'b0, 1'b0); tick();
    check("br_taken_nonzero", pc, 40);
    branch(4'd5, 1'b0, 1'b0); tick();
    check("br_unwritten", pc, 0);
    branch_en = 1'b0;

    lut_we = 1'b1; lut_addr = 4'd3; lut_data = 10'd100;
    tick();
    lut_we = 1'b0;
    check("lut_we_run_pc", pc, 1);
    repeat (6) tick();
    check("seq_pc7", pc, 7);

    halt = 1'b1; branch(4'd3, 1'b1, 1'b1);
    tick();
    halt = 1'b0; branch_en = 1'b0;
    check("halt_pc", pc, 7);
    check("halt_done", done, 1);
    check("halt_running", running, 0);
    check("halt_err", err, 0);
    check("halt_ovf_held", ovf_flag, 1);
    tick();
    check("halted_pc_hold", pc, 7);
    check("halted_done_hold", done, 1);

    lut_we = 1'b1; lut_addr = 4'd6; lut_data = 10'd200;
    tick();
    lut_we = 1'b0;

    start = 1'b1; tick(); start = 1'b0;
    check("restart_pc", pc, 0);
    check("restart_done", done, 0);
    check("restart_running", running, 1);
    check("restart_ovf", ovf_flag, 0);
    branch(4'd3, 1'b1, 1'b1); tick();
    check("lut_run_write_ignored", pc, 40);
    branch(4'd6, 1'b1, 1'b1); tick();
    check("lut_halted_write", pc, 200);
    branch(4'd0, 1'b1, 1'b1); tick();
    branch_en = 1'b0;
    check("br_to_zero", pc, 0);
    repeat (9) tick();
    check("seq_pc9", pc, 9);

    reset = 1'b1; start = 1'b1; ovf_we = 1'b1; overflow_in = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; ovf_we = 1'b0; overflow_in = 1'b0;
    check("midrun_rst_pc", pc, 0);
    check("midrun_rst_running", running, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_ovf", ovf_flag, 0);
    tick();
    check("post_rst_idle", running, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("post_rst_pc1", pc, 1);
    branch(4'd3, 1'b1, 1'b1); tick();
    branch_en = 1'b0;
    check("lut_cleared", pc, 0);

    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("ovr_pc0", pc2, 0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("ovr_seq", pc2, i);
    end
    check("ovr_running_at_max", running2, 1);
    check("ovr_err_at_max", err2, 0);
    tick();
    check("ovr_pc_hold", pc2, 15);
    check("ovr_err", err2, 1);
    check("ovr_done", done2, 1);
    check("ovr_running", running2, 0);
    repeat (3) begin
      tick();
      check("ovr_no_wrap", pc2, 15);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
